dma_xfer_ctrl: RTL and testbench

Memory-to-memory transfer sequencer that drives the native side of the AXI DMA engine.
- Software programs source address, destination address, word count and maximum burst length, then pulses start.
- The block splits the transfer into bursts; each burst is read into an internal buffer, then written back out.
- It sits between the CPU-side register bank and the AXI DMA native interface, and owns that interface exclusively while busy.

---
 rtl/dma_xfer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dma_xfer_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_ctrl.sv
// Memory-to-memory DMA sequencer: splits a programmed transfer into bursts,
// reads each burst into a local buffer, then writes it back to the destination.
module dma_xfer_ctrl #(
   parameter int DMA_DATA_W = 32,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 8,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       src_addr,
   input  logic [ADDR_W-1:0]       dst_addr,
   input  logic [CNT_W-1:0]        xfer_words,
   input  logic [LEN_W-1:0]        burst_len,
   output logic                    busy,
   output logic                    done,
   output logic                    valid,
   output logic [ADDR_W-1:0]       address,
   output logic [DMA_DATA_W-1:0]   wdata,
   output logic [DMA_DATA_W/8-1:0] wstrb,
   input  logic [DMA_DATA_W-1:0]   rdata,
   input  logic                    ready,
   output logic [LEN_W-1:0]        dma_len,
   input  logic                    dma_ready
);

   localparam int DEPTH = 2 ** LEN_W;
   localparam int BW    = LEN_W + 1;
   localparam int CW    = (CNT_W > BW) ? CNT_W : BW;
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DMA_DATA_W / 8);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RD      = 3'd2,
      WR_WAIT = 3'd3,
      WR      = 3'd4,
      NEXT    = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t state_reg, state_next;

   logic [ADDR_W-1:0]     rd_ptr_reg;
   logic [ADDR_W-1:0]     wr_ptr_reg;
   logic [CNT_W-1:0]      remaining_reg;
   logic [LEN_W-1:0]      max_len_reg;
   logic [LEN_W-1:0]      len_reg;
   logic [BW-1:0]         beat_reg;
   logic [DMA_DATA_W-1:0] buffer [0:DEPTH-1];

   logic [BW-1:0]     max_beats;
   logic [BW-1:0]     beats;
   logic [CW-1:0]     rem_ext;
   logic [CW-1:0]     max_ext;
   logic              last_beat;
   logic [ADDR_W-1:0] step;

   // remaining only changes in NEXT, so beats is constant for a whole burst
   assign max_beats = {1'b0, max_len_reg} + BW'(1);
   assign rem_ext   = CW'(remaining_reg);
   assign max_ext   = CW'(max_beats);
   assign beats     = (rem_ext < max_ext) ? BW'(rem_ext) : max_beats;
   assign last_beat = (beat_reg == (beats - BW'(1)));
   assign step      = ADDR_W'(beats) * WORD_BYTES;
   assign dma_len   = len_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (xfer_words == '0) ? DONE : RD_WAIT;
            end
         end
         RD_WAIT: if (dma_ready) state_next = RD;
         RD:      if (ready && last_beat) state_next = WR_WAIT;
         WR_WAIT: if (dma_ready) state_next = WR;
         WR:      if (ready && last_beat) state_next = NEXT;
         NEXT:    state_next = (remaining_reg == CNT_W'(beats)) ? DONE : RD_WAIT;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      valid   = 1'b0;
      address = '0;
      wdata   = '0;
      wstrb   = '0;
      case (state_reg)
         RD_WAIT, WR_WAIT, NEXT: busy = 1'b1;
         RD: begin
            busy    = 1'b1;
            valid   = 1'b1;
            address = rd_ptr_reg;
         end
         WR: begin
            busy    = 1'b1;
            valid   = 1'b1;
            address = wr_ptr_reg;
            wstrb   = '1;
            wdata   = buffer[beat_reg[LEN_W-1:0]];
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_reg    <= '0;
         wr_ptr_reg    <= '0;
         remaining_reg <= '0;
         max_len_reg   <= '0;
         len_reg       <= '0;
         beat_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  rd_ptr_reg    <= src_addr;
                  wr_ptr_reg    <= dst_addr;
                  remaining_reg <= xfer_words;
                  max_len_reg   <= burst_len;
                  beat_reg      <= '0;
               end
            end
            RD_WAIT: len_reg <= LEN_W'(beats - BW'(1));
            RD, WR: begin
               if (ready) begin
                  beat_reg <= last_beat ? '0 : beat_reg + BW'(1);
               end
            end
            NEXT: begin
               rd_ptr_reg    <= rd_ptr_reg + step;
               wr_ptr_reg    <= wr_ptr_reg + step;
               remaining_reg <= remaining_reg - CNT_W'(beats);
               beat_reg      <= '0;
            end
            default: ;
         endcase
      end
   end

   // Burst buffer holds no reset; contents are only read after being filled
   always_ff @(posedge clk) begin
      if (state_reg == RD && ready) begin
         buffer[beat_reg[LEN_W-1:0]] <= rdata;
      end
   end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Self-checking bench for dma_xfer_ctrl: a burst-list model plus a native-side
// memory responder, checked every cycle, with directed transfers on top.
module tb_dma_xfer_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] xfer_words;
   logic [7:0]  burst_len;
   logic        busy;
   logic        done;
   logic        valid;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;
   logic [7:0]  dma_len;
   logic        dma_ready;

   dma_xfer_ctrl #(
      .DMA_DATA_W(32), .ADDR_W(32), .LEN_W(8), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .xfer_words(xfer_words), .burst_len(burst_len), .busy(busy), .done(done),
      .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb), .rdata(rdata),
      .ready(ready), .dma_len(dma_len), .dma_ready(dma_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // source memory content is a pure function of the word address
   function automatic logic [31:0] src_word(input logic [31:0] a);
      return {8'hA5, 12'h000, a[13:2]};
   endfunction

   logic [31:0] dst_mem [0:4095];
   logic [31:0] ph_addr [$];
   int          ph_len [$];
   bit          ph_wr [$];
   int          ph_beats [$];
   logic [31:0] rq [$];
   bit          active = 0, in_phase = 0, cur_wr = 0, just_ended = 0;
   logic [31:0] cur_addr;
   int          cur_len, cur_beats, cur_k;
   int          done_cnt = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
   logic [31:0] log_addr [16];
   int          log_len [16];
   bit          log_wr [16];
   int          nlog = 0;
   bit          stall_mode = 0, gap_mode = 0;
   int          dma_low = 0;
   bit          prev_dma_ready = 1, prev_valid = 0, prev_ready = 0;
   logic [31:0] prev_address, prev_wdata;
   logic [3:0]  prev_wstrb;
   logic [7:0]  prev_len;
   int          wr_beat_now = -1;

   // compare + responder: samples DUT at negedge, then drives ready/rdata/dma_ready
   initial begin
      ready = 1'b0;
      rdata = '0;
      dma_ready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         wr_beat_now = -1;
         if (!rst) begin
            check("rst_valid", valid, 0);
            check("rst_done", done, 0);
            active = 0; in_phase = 0; just_ended = 0; dma_low = 0;
            ph_addr.delete(); ph_len.delete(); ph_wr.delete(); ph_beats.delete(); rq.delete();
            ready = 1'b0; rdata = '0; dma_ready = 1'b1;
            prev_dma_ready = 1; prev_valid = 0; prev_ready = 0;
         end else begin
            if (valid) begin
               if (!in_phase) begin
                  check("burst_start_dma_ready", prev_dma_ready, 1);
                  check("valid_after_last_beat", just_ended, 0);
                  check("phase_pending", ph_addr.size() != 0, 1);
                  if (ph_addr.size() != 0) begin
                     cur_addr  = ph_addr.pop_front();
                     cur_len   = ph_len.pop_front();
                     cur_wr    = ph_wr.pop_front();
                     cur_beats = ph_beats.pop_front();
                     cur_k     = 0;
                     in_phase  = 1;
                     if (nlog < 16) begin
                        log_addr[nlog] = cur_addr;
                        log_len[nlog]  = cur_len;
                        log_wr[nlog]   = cur_wr;
                     end
                     nlog++;
                  end
               end
               if (in_phase) begin
                  check("address", address, cur_addr);
                  check("dma_len", dma_len, cur_len);
                  check("wstrb", wstrb, cur_wr ? 4'hF : 4'h0);
                  if (cur_wr) begin
                     wr_beat_now = cur_k;
                     check("wdata", wdata, rq[cur_k]);
                  end
               end
            end else if (in_phase) begin
               check("valid_dropped", valid, 1);
            end
            just_ended = 0;
            if (prev_valid && !prev_ready) begin
               check("stall_valid", valid, 1);
               check("stall_address", address, prev_address);
               check("stall_wstrb", wstrb, prev_wstrb);
               check("stall_wdata", wdata, prev_wdata);
               check("stall_dma_len", dma_len, prev_len);
            end
            check("busy", busy, active && !done);
            if (done) begin
               check("done_while_active", active, 1);
               check("done_phases_left", ph_addr.size() + int'(in_phase), 0);
               active = 0;
               done_cnt++;
               done_cyc = cyc;
            end

            ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (valid && in_phase && !cur_wr && ready)
               rdata = src_word(cur_addr + 32'(4 * cur_k));
            else
               rdata = $urandom;
            if (valid && in_phase && ready) begin
               if (cur_wr) dst_mem[(cur_addr + 32'(4 * cur_k)) >> 2 & 32'hFFF] = wdata;
               else        rq.push_back(rdata);
               cur_k++;
               if (cur_k == cur_beats) begin
                  in_phase = 0;
                  just_ended = 1;
                  if (cur_wr) rq.delete();
                  if (gap_mode) dma_low = 5;
               end
            end
            if (dma_low > 0) begin
               dma_ready = 1'b0;
               dma_low--;
            end else begin
               dma_ready = 1'b1;
            end

            if (start && !active && !done) begin
               int rem, off, b;
               rem = int'(xfer_words);
               off = 0;
               while (rem > 0) begin
                  b = (rem < int'(burst_len) + 1) ? rem : int'(burst_len) + 1;
                  ph_addr.push_back(src_addr + 32'(4 * off)); ph_len.push_back(b - 1);
                  ph_wr.push_back(0); ph_beats.push_back(b);
                  ph_addr.push_back(dst_addr + 32'(4 * off)); ph_len.push_back(b - 1);
                  ph_wr.push_back(1); ph_beats.push_back(b);
                  rem -= b;
                  off += b;
               end
               for (int i = 0; i < 4096; i++) dst_mem[i] = '0;
               active = 1;
               start_cyc = cyc;
               nlog = 0;
            end
            prev_dma_ready = dma_ready;
            prev_valid = valid;
            prev_ready = ready;
            prev_address = address;
            prev_wdata = wdata;
            prev_wstrb = wstrb;
            prev_len = dma_len;
         end
      end
   end

   task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n, input int b);
      @(posedge clk); #1;
      src_addr = s; dst_addr = d; xfer_words = 16'(n); burst_len = 8'(b);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, input string name);
      for (int i = 0; i < 3000 && done_cnt == base; i++) begin
         @(negedge clk); #1;
      end
      check(name, done_cnt > base, 1);
      repeat (10) @(negedge clk);
      #1;
      check({name, "_once"}, done_cnt, base + 1);
   endtask

   task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int b, input string name);
      int base;
      base = done_cnt;
      kick(s, d, n, b);
      wait_done(base, name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, dc;
      rst = 1'b0; start = 1'b0;
      src_addr = '0; dst_addr = '0; xfer_words = '0; burst_len = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_valid", valid, 0);
      check("reset_address", address, 0);
      check("reset_wdata", wdata, 0);
      check("reset_wstrb", wstrb, 0);
      check("reset_dma_len", dma_len, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // single 4-beat burst
      run_xfer(32'h1000, 32'h2000, 4, 3, "t1_done");
      $display("t1: 4 words, burst 3, latency=%0d", done_cyc - start_cyc);
      check("t1_latency", done_cyc - start_cyc, 12);
      check("t1_nphase", nlog, 2);
      check("t1_rd_addr", log_addr[0], 32'h1000);
      check("t1_rd_len", log_len[0], 3);
      check("t1_wr_addr", log_addr[1], 32'h2000);
      check("t1_wr_flag", log_wr[1], 1);
      check("t1_mem0", dst_mem[12'h800], 32'hA5000400);
      check("t1_mem3", dst_mem[12'h803], 32'hA5000403);

      // 10 words split 4/4/2
      run_xfer(32'h1000, 32'h2000, 10, 3, "t2_done");
      $display("t2: 10 words, burst 3, phases=%0d", nlog);
      check("t2_nphase", nlog, 6);
      check("t2_rd1", log_addr[2], 32'h1010);
      check("t2_wr1", log_addr[3], 32'h2010);
      check("t2_rd2", log_addr[4], 32'h1020);
      check("t2_wr2", log_addr[5], 32'h2020);
      check("t2_len1", log_len[2], 3);
      check("t2_len2", log_len[4], 1);
      check("t2_len2w", log_len[5], 1);
      check("t2_mem9", dst_mem[12'h809], 32'hA5000409);

      // zero-word transfer
      run_xfer(32'h1000, 32'h2000, 0, 3, "t3_done");
      $display("t3: 0 words, latency=%0d", done_cyc - start_cyc);
      check("t3_latency", done_cyc - start_cyc, 1);
      check("t3_nphase", nlog, 0);

      // stalls and dma_ready gaps, 37 words burst 7
      stall_mode = 1; gap_mode = 1;
      run_xfer(32'h1000, 32'h2000, 37, 7, "t4_done");
      stall_mode = 0; gap_mode = 0;
      $display("t4: 37 words, burst 7, stalled, phases=%0d", nlog);
      check("t4_nphase", nlog, 10);
      check("t4_last_len", log_len[8], 4);
      for (int i = 0; i < 37; i++)
         check("t4_mem", dst_mem[12'h800 + 12'(i)], src_word(32'h1000 + 32'(4 * i)));

      // start while busy must be ignored
      base = done_cnt;
      kick(32'h1200, 32'h2400, 6, 1);
      repeat (4) @(negedge clk);
      kick(32'h0000, 32'h3000, 3, 0);
      wait_done(base, "t5_done");
      $display("t5: restart while busy, phases=%0d", nlog);
      check("t5_nphase", nlog, 6);
      check("t5_rd0", log_addr[0], 32'h1200);
      check("t5_wr2", log_addr[5], 32'h2410);
      check("t5_mem5", dst_mem[12'h905], 32'hA5000485);
      check("t5_untouched", dst_mem[12'hC00], 0);

      // reset during third beat of a write burst
      kick(32'h1000, 32'h2000, 8, 7);
      for (int i = 0; i < 200 && wr_beat_now != 2; i++) begin
         @(negedge clk); #1;
      end
      check("t6_reach_beat3", wr_beat_now, 2);
      dc = done_cnt;
      #1 rst = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_valid", valid, 0);
      check("t6_address", address, 0);
      check("t6_wstrb", wstrb, 0);
      check("t6_wdata", wdata, 0);
      check("t6_dma_len", dma_len, 0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_no_done", done_cnt, dc);
      $display("t6: reset mid write, done_count=%0d", done_cnt);
      run_xfer(32'h1000, 32'h2000, 4, 3, "t6_rerun_done");
      check("t6_rerun_latency", done_cyc - start_cyc, 12);
      check("t6_rerun_mem2", dst_mem[12'h802], 32'hA5000402);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
